// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg
//   Shared CPU type definitions: MIPS opcode/funct encodings, the
//   next-PC select encoding driven by the control unit as {JReg,PcSrc},
//   and the fetch sequencer state type.
package cpu_types_pkg;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_JAL   = 6'h03,
    OP_BEQ   = 6'h04,
    OP_BNE   = 6'h05,
    OP_ADDI  = 6'h08,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B,
    OP_HALT  = 6'h3F
  } opcode_t;

  typedef enum logic [5:0] {
    FN_SLL = 6'h00,
    FN_JR  = 6'h08,
    FN_ADD = 6'h20,
    FN_SUB = 6'h22,
    FN_AND = 6'h24,
    FN_OR  = 6'h25,
    FN_SLT = 6'h2A
  } funct_t;

  // {JReg, PcSrc} as presented by the control unit.
  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JREG   = 2'b10,
    PC_JUMP   = 2'b11
  } pc_sel_t;

  typedef enum logic [1:0] {
    FETCH  = 2'b00,
    EXEC   = 2'b01,
    MEM    = 2'b10,
    HALTED = 2'b11
  } fetch_state_t;

endpackage

// File: rtl/next_pc_mux.sv
// next_pc_mux
//   Combinational next-PC selection.
//   Ports:
//     pc_plus4  in  32  PC+4 of the current instruction
//     instr     in  32  current instruction register
//     rs_data   in  32  register rs value (JR target)
//     pc_sel    in  2   {JReg, PcSrc}
//     next_pc   out 32  selected next PC (all adds modulo 2^32)
module next_pc_mux
  import cpu_types_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [1:0]  pc_sel,
  output logic [31:0] next_pc
);

  logic [31:0] branch_off;

  // Sign-extended word offset, already scaled to bytes.
  assign branch_off = {{14{instr[15]}}, instr[15:0], 2'b00};

  always_comb begin
    // NOTE: every always_comb output gets a default before the case so no
    //       path leaves it unassigned, which would infer a latch.
    next_pc = pc_plus4;
    case (pc_sel_t'(pc_sel))
      PC_SEQ:    next_pc = pc_plus4;
      PC_BRANCH: next_pc = pc_plus4 + branch_off;
      PC_JUMP:   next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
      PC_JREG:   next_pc = rs_data;
      default:   next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Owns PC and instruction register; sequences I-cache fetch, the
//   decode/execute cycle and an optional D-cache access, then retires the
//   instruction with a one-cycle commit pulse and advances the PC.
//   Ports:
//     CLK, RST              clock, synchronous active-high reset
//     ihit, imemload        I-cache hit and instruction word
//     dhit                  D-cache hit, completes the data access
//     PcSrc, JReg, Halt     control-unit PC select and HALT decode
//     dMemRe, dMemWr        control-unit load / store
//     rs_data               JR target
//     imemREN, imemaddr     I-cache request and current PC
//     dmemREN, dmemWEN      D-cache requests
//     instr, InstrOp, InstrFunc  instruction register and its fields
//     pc_plus4              PC+4 (JAL link value)
//     commit                instruction retires this cycle
//     halt                  sticky halted flag
module fetch_sequencer #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  input  logic        dhit,
  input  logic        PcSrc,
  input  logic        JReg,
  input  logic        Halt,
  input  logic        dMemRe,
  input  logic        dMemWr,
  input  logic [31:0] rs_data,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic [31:0] instr,
  output logic [5:0]  InstrOp,
  output logic [5:0]  InstrFunc,
  output logic [31:0] pc_plus4,
  output logic        commit,
  output logic        halt
);
  import cpu_types_pkg::*;

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic         halt_q, halt_d;
  logic [31:0]  next_pc;
  logic         imem_ren, dmem_ren, dmem_wen, commit_c;

  assign pc_plus4 = pc_q + 32'd4;

  next_pc_mux u_next_pc_mux (
    .pc_plus4 (pc_plus4),
    .instr    (instr_q),
    .rs_data  (rs_data),
    .pc_sel   ({JReg, PcSrc}),
    .next_pc  (next_pc)
  );

  always_ff @(posedge CLK) begin
    // NOTE: state registers use non-blocking assignments so every flop
    //       samples the pre-edge values regardless of statement order.
    if (RST) begin
      state_q <= FETCH;
      pc_q    <= PC_INIT;
      instr_q <= '0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      halt_q  <= halt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    halt_d   = halt_q;
    imem_ren = 1'b0;
    dmem_ren = 1'b0;
    dmem_wen = 1'b0;
    commit_c = 1'b0;
    case (state_q)
      FETCH: begin
        imem_ren = 1'b1;
        if (ihit) begin
          instr_d = imemload;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (Halt) begin
          halt_d  = 1'b1;
          state_d = HALTED;
        end else if (dMemRe || dMemWr) begin
          state_d = MEM;
        end else begin
          commit_c = 1'b1;
          pc_d     = next_pc;
          state_d  = FETCH;
        end
      end
      MEM: begin
        // Both strobes pass through unarbitrated.
        dmem_ren = dMemRe;
        dmem_wen = dMemWr;
        if (dhit) begin
          commit_c = 1'b1;
          pc_d     = next_pc;
          state_d  = FETCH;
        end
      end
      HALTED: begin
        halt_d = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  // Requests and commit are dropped in the very cycle reset is sampled.
  assign imemREN   = imem_ren & ~RST;
  assign dmemREN   = dmem_ren & ~RST;
  assign dmemWEN   = dmem_wen & ~RST;
  assign commit    = commit_c & ~RST;
  assign imemaddr  = pc_q;
  assign instr     = instr_q;
  assign InstrOp   = instr_q[31:26];
  assign InstrFunc = instr_q[5:0];
  assign halt      = halt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer
//   Directed bench: the bench plays the control unit and both caches.
//   Inputs change and outputs are sampled around the falling edge.
module tb_fetch_sequencer;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ihit;
  logic [31:0] imemload;
  logic        dhit;
  logic        PcSrc, JReg, Halt, dMemRe, dMemWr;
  logic [31:0] rs_data;
  logic        imemREN, dmemREN, dmemWEN, commit, halt;
  logic [31:0] imemaddr, instr, pc_plus4;
  logic [5:0]  InstrOp, InstrFunc;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [31:0] ADDI_W = 32'h2001_0005;
  localparam logic [31:0] JR_W   = 32'h03E0_0008;
  localparam logic [31:0] BEQ_M1 = 32'h1000_FFFF;
  localparam logic [31:0] BEQ_P3 = 32'h1000_0003;
  localparam logic [31:0] J_W    = 32'h0800_0040;
  localparam logic [31:0] LW_W   = 32'h8C01_0000;
  localparam logic [31:0] SW_W   = 32'hAC01_0000;
  localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;

  fetch_sequencer #(.PC_INIT(32'h0000_0040)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .ihit      (ihit),
    .imemload  (imemload),
    .dhit      (dhit),
    .PcSrc     (PcSrc),
    .JReg      (JReg),
    .Halt      (Halt),
    .dMemRe    (dMemRe),
    .dMemWr    (dMemWr),
    .rs_data   (rs_data),
    .imemREN   (imemREN),
    .imemaddr  (imemaddr),
    .dmemREN   (dmemREN),
    .dmemWEN   (dmemWEN),
    .instr     (instr),
    .InstrOp   (InstrOp),
    .InstrFunc (InstrFunc),
    .pc_plus4  (pc_plus4),
    .commit    (commit),
    .halt      (halt)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge CLK);
  endtask

  // In FETCH: present an instruction with ihit; ends in EXEC.
  task automatic do_fetch(input logic [31:0] word, input logic [31:0] pc);
    ihit = 1'b1; imemload = word;
    PcSrc = 1'b0; JReg = 1'b0; Halt = 1'b0; dMemRe = 1'b0; dMemWr = 1'b0;
    #1;
    check("fetch_addr",   imemaddr,       pc);
    check("fetch_ren",    32'(imemREN),   32'd1);
    check("fetch_commit", 32'(commit),    32'd0);
    tick;
    ihit = 1'b0; imemload = 32'hDEAD_BEEF;
  endtask

  // In EXEC for a non-memory instruction; ends in next FETCH.
  task automatic do_exec(input logic jreg, input logic pcsrc,
                         input logic [31:0] rs, input logic [31:0] exp_pc);
    JReg = jreg; PcSrc = pcsrc; rs_data = rs;
    ihit = 1'b1;  // ignored outside FETCH
    #1;
    check("exec_commit", 32'(commit),  32'd1);
    check("exec_ren",    32'(imemREN), 32'd0);
    tick;
    ihit = 1'b0;
    #1;
    check("next_pc",     imemaddr,     exp_pc);
    check("post_commit", 32'(commit),  32'd0);
  endtask

  initial begin
    RST = 1'b1; ihit = 1'b0; imemload = '0; dhit = 1'b0;
    PcSrc = 1'b0; JReg = 1'b0; Halt = 1'b0; dMemRe = 1'b0; dMemWr = 1'b0;
    rs_data = '0;
    tick; tick;
    #1;
    check("rst_pc",     imemaddr,      32'h40);
    check("rst_instr",  instr,         32'h0);
    check("rst_halt",   32'(halt),     32'd0);
    check("rst_ren",    32'(imemREN),  32'd0);
    check("rst_commit", 32'(commit),   32'd0);
    RST = 1'b0;

    // ADDI at PC_INIT: commit in cycle 2, PC+4 in cycle 3
    do_fetch(ADDI_W, 32'h40);
    check("addi_instr", instr,          ADDI_W);
    check("addi_op",    32'(InstrOp),   32'h08);
    check("addi_fn",    32'(InstrFunc), 32'h05);
    do_exec(1'b0, 1'b0, 32'h0, 32'h44);
    check("ihit_ignored", instr, ADDI_W);

    // JR to 0x100
    do_fetch(JR_W, 32'h44);
    check("jr_fn", 32'(InstrFunc), 32'h08);
    do_exec(1'b1, 1'b0, 32'h100, 32'h100);

    // BEQ imm=-1 at 0x100 -> 0x100; imm=3 -> 0x110
    do_fetch(BEQ_M1, 32'h100);
    check("beq_pc4", pc_plus4, 32'h104);
    do_exec(1'b0, 1'b1, 32'h0, 32'h100);
    do_fetch(BEQ_P3, 32'h100);
    do_exec(1'b0, 1'b1, 32'h0, 32'h110);

    // J target 0x40 from 0x110 -> 0x100; JR 0x2000
    do_fetch(J_W, 32'h110);
    do_exec(1'b1, 1'b1, 32'h0, 32'h100);
    do_fetch(JR_W, 32'h100);
    do_exec(1'b1, 1'b0, 32'h2000, 32'h2000);

    // LW with three dhit-miss cycles
    do_fetch(LW_W, 32'h2000);
    dMemRe = 1'b1;
    #1;
    check("lw_exec_commit", 32'(commit),  32'd0);
    check("lw_exec_dren",   32'(dmemREN), 32'd0);
    tick;
    for (int i = 0; i < 4; i++) begin
      dhit = (i == 3);
      #1;
      check("lw_dren",   32'(dmemREN), 32'd1);
      check("lw_dwen",   32'(dmemWEN), 32'd0);
      check("lw_pc",     imemaddr,     32'h2000);
      check("lw_commit", 32'(commit),  (i == 3) ? 32'd1 : 32'd0);
      tick;
    end
    dhit = 1'b0; dMemRe = 1'b0;
    #1;
    check("lw_next_pc", imemaddr,    32'h2004);
    check("lw_post",    32'(commit), 32'd0);

    // SW with immediate hit
    do_fetch(SW_W, 32'h2004);
    dMemWr = 1'b1;
    tick;
    dhit = 1'b1;
    #1;
    check("sw_dwen",   32'(dmemWEN), 32'd1);
    check("sw_dren",   32'(dmemREN), 32'd0);
    check("sw_commit", 32'(commit),  32'd1);
    tick;
    dhit = 1'b0; dMemWr = 1'b0;
    #1;
    check("sw_next_pc", imemaddr, 32'h2008);

    // I-cache miss for five cycles
    for (int i = 0; i < 5; i++) begin
      ihit = 1'b0;
      #1;
      check("miss_ren",    32'(imemREN), 32'd1);
      check("miss_instr",  instr,        SW_W);
      check("miss_commit", 32'(commit),  32'd0);
      check("miss_pc",     imemaddr,     32'h2008);
      tick;
    end

    // Reset during MEM
    do_fetch(LW_W, 32'h2008);
    dMemRe = 1'b1;
    tick;
    #1;
    check("mem_dren", 32'(dmemREN), 32'd1);
    RST = 1'b1; dhit = 1'b1;
    #1;
    check("rstmem_dren",   32'(dmemREN), 32'd0);
    check("rstmem_commit", 32'(commit),  32'd0);
    check("rstmem_iren",   32'(imemREN), 32'd0);
    tick;
    #1;
    check("rstmem_pc",    imemaddr, 32'h40);
    check("rstmem_instr", instr,    32'h0);
    RST = 1'b0; dhit = 1'b0; dMemRe = 1'b0;
    #1;
    check("rstmem_fetch", 32'(imemREN), 32'd1);

    // PC wrap at the top of the address space
    do_fetch(JR_W, 32'h40);
    do_exec(1'b1, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    do_fetch(ADDI_W, 32'hFFFF_FFFC);
    check("wrap_pc4", pc_plus4, 32'h0);
    do_exec(1'b0, 1'b0, 32'h0, 32'h0);

    // HALT
    do_fetch(HALT_W, 32'h0);
    Halt = 1'b1;
    #1;
    check("halt_exec_commit", 32'(commit), 32'd0);
    check("halt_exec_flag",   32'(halt),   32'd0);
    tick;
    Halt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ihit = 1'b1; dhit = 1'b1; dMemRe = 1'b1;
      #1;
      check("halted_flag",   32'(halt),    32'd1);
      check("halted_iren",   32'(imemREN), 32'd0);
      check("halted_dren",   32'(dmemREN), 32'd0);
      check("halted_commit", 32'(commit),  32'd0);
      check("halted_pc",     imemaddr,     32'h0);
      tick;
    end
    ihit = 1'b0; dhit = 1'b0; dMemRe = 1'b0;
    RST = 1'b1;
    tick;
    #1;
    check("unhalt_flag", 32'(halt), 32'd0);
    check("unhalt_pc",   imemaddr,  32'h40);
    RST = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
